// File: rtl/video_pkg.sv
// Shared types and constants for the video frame-buffer path.
//   fsm_state_t  : writer burst FSM states
//   PIX_BYTES    : bytes per pixel word on the Avalon bus
//   BURSTCOUNT_W : width of avl_burstcount
package video_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } fsm_state_t;

  localparam int unsigned PIX_BYTES    = 4;
  localparam int unsigned BURSTCOUNT_W = 5;

endpackage

// File: rtl/avalon_stream_writer_if.sv
// Pixel stream input plus Avalon-MM burst write bus of the stream writer.
//   s_valid/s_ready/s_data/s_sof : pixel stream (writer is the sink)
//   avl_*                        : Avalon write master towards the SDRAM interconnect
// Modports:
//   master : writer view (sinks the stream, drives the Avalon bus)
//   slave  : environment view (sources the stream, answers waitrequest)
interface avalon_stream_writer_if;

  logic                                s_valid;
  logic                                s_ready;
  logic [31:0]                         s_data;
  logic                                s_sof;
  logic [31:0]                         avl_address;
  logic [3:0]                          avl_byteenable;
  logic                                avl_write;
  logic                                avl_read;
  logic [31:0]                         avl_writedata;
  logic [video_pkg::BURSTCOUNT_W-1:0]  avl_burstcount;
  logic                                avl_waitrequest;

  modport master (
    input  s_valid, s_data, s_sof, avl_waitrequest,
    output s_ready, avl_address, avl_byteenable, avl_write, avl_read,
           avl_writedata, avl_burstcount
  );

  modport slave (
    output s_valid, s_data, s_sof, avl_waitrequest,
    input  s_ready, avl_address, avl_byteenable, avl_write, avl_read,
           avl_writedata, avl_burstcount
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. rdata always shows the head word.
//   clk, rst_n : clock, async active-low reset (flushes pointers/count)
//   push/wdata : write a word (caller guarantees !full)
//   pop        : drop the head word (caller guarantees !empty)
//   rdata      : head word
//   full/empty : status, derived from the registered count
//   count      : words held, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/avalon_stream_writer.sv
// Pixel stream to frame buffer writer. Syncs to the first start-of-frame
// pixel, buffers pixels in a FIFO and issues fixed-length Avalon write bursts
// walking linearly from BASE, wrapping at the end of a frame.
//   clk, reset_n : clock, async active-low reset
//   bus          : stream sink + Avalon burst write master (master modport)
//   frame_done   : one-cycle pulse after the last beat of a frame is accepted
//   frame_err    : sticky, sof seen while the input pixel counter was non-zero
module avalon_stream_writer
  import video_pkg::fsm_state_t, video_pkg::PIX_BYTES, video_pkg::BURSTCOUNT_W;
#(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480,
  parameter int unsigned BURST = 16,
  parameter int unsigned DEPTH = 32,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avalon_stream_writer_if.master  bus,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam int unsigned FRAME     = HDISP * VDISP;
  localparam int unsigned NBURSTS   = FRAME / BURST;
  localparam int unsigned PCW       = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int unsigned BIW       = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;
  localparam int unsigned BCW       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [31:0] ADDR_STEP = 32'(PIX_BYTES * BURST);

  fsm_state_t     state_q, state_d;
  logic           write_q, write_d;
  logic [31:0]    addr_q, addr_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [BIW-1:0] bidx_q, bidx_d;
  logic [PCW-1:0] pix_q, pix_d;
  logic           synced_q, synced_d;
  logic           live_q;
  logic           frame_done_q, frame_done_d;
  logic           frame_err_q, frame_err_d;

  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    fifo_rdata;

  logic           s_ready_c;
  logic           accept_c;
  logic           push_c;
  logic           beat_c;
  logic           pop_c;

  // Unsynced pixels are accepted and dropped; once synced, only FIFO space gates input.
  assign s_ready_c = live_q && (!synced_q || !fifo_full);
  assign accept_c  = bus.s_valid && s_ready_c;
  assign push_c    = accept_c && (synced_q || bus.s_sof);
  assign beat_c    = write_q && !bus.avl_waitrequest;
  assign pop_c     = beat_c && !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push_c),
    .wdata (bus.s_data),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= video_pkg::IDLE;
      write_q      <= 1'b0;
      addr_q       <= BASE;
      beat_q       <= '0;
      bidx_q       <= '0;
      pix_q        <= '0;
      synced_q     <= 1'b0;
      live_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      bidx_q       <= bidx_d;
      pix_q        <= pix_d;
      synced_q     <= synced_d;
      live_q       <= 1'b1;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Input sync/pixel counting, burst FSM, beat counter and address generator.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    bidx_d       = bidx_q;
    pix_d        = pix_q;
    synced_d     = synced_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;

    if (push_c) begin
      pix_d = (pix_q == PCW'(FRAME - 1)) ? '0 : pix_q + PCW'(1);
    end

    // A stray sof is flagged but neither resets the counter nor resyncs.
    if (accept_c && bus.s_sof) begin
      synced_d = 1'b1;
      if (pix_q != '0) frame_err_d = 1'b1;
    end

    case (state_q)
      video_pkg::IDLE: begin
        if (fifo_count >= CW'(BURST)) begin
          state_d = video_pkg::BURST;
          write_d = 1'b1;
        end
      end
      video_pkg::BURST: begin
        if (beat_c) begin
          if (beat_q == BCW'(BURST - 1)) begin
            state_d = video_pkg::IDLE;
            write_d = 1'b0;
            beat_d  = '0;
            if (bidx_q == BIW'(NBURSTS - 1)) begin
              bidx_d       = '0;
              addr_d       = BASE;
              frame_done_d = 1'b1;
            end else begin
              bidx_d = bidx_q + BIW'(1);
              addr_d = addr_q + ADDR_STEP;
            end
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = video_pkg::IDLE;
        write_d = 1'b0;
      end
    endcase
  end

  assign bus.s_ready        = s_ready_c;
  assign bus.avl_address    = addr_q;
  assign bus.avl_byteenable = 4'hF;
  assign bus.avl_write      = write_q;
  assign bus.avl_read       = 1'b0;
  assign bus.avl_writedata  = fifo_rdata;
  assign bus.avl_burstcount = BURSTCOUNT_W'(BURST);
  assign frame_done         = frame_done_q;
  assign frame_err          = frame_err_q;

endmodule

// File: tb/tb_avalon_stream_writer.sv
// Scoreboard bench for avalon_stream_writer: the driver pushes the expected
// (address, data, last-of-frame) of every pixel that should reach the frame
// buffer; a monitor pops and compares on each accepted Avalon beat.
module tb_avalon_stream_writer;

  localparam int unsigned HD = 4;
  localparam int unsigned VD = 2;
  localparam int unsigned BL = 4;
  localparam int unsigned DP = 8;
  localparam logic [31:0] BASE_A = 32'h100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_done;
  logic frame_err;

  avalon_stream_writer_if bus();

  avalon_stream_writer #(
    .HDISP (HD),
    .VDISP (VD),
    .BURST (BL),
    .DEPTH (DP),
    .BASE  (BASE_A)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  exp_t        exp_q[$];
  int          k_m        = 0;
  bit          synced_m   = 1'b0;
  int          accepts    = 0;
  int          beats_seen = 0;
  logic [31:0] dcnt       = 32'hA000_0000;
  bit          fd_pend    = 1'b0;
  bit          gap_due    = 1'b0;
  int          bib        = 0;
  bit          tx_done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Drive one pixel (entered/left just after a rising edge); model the sync rule.
  task automatic send(input logic sof);
    int n;
    logic [31:0] d;
    exp_t e;
    n = 0;
    d = dcnt;
    dcnt = dcnt + 32'd1;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    @(negedge clk);
    while (!bus.s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      timeout_fail("s_ready_wait");
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accepts++;
    if (synced_m || sof) begin
      e.addr = BASE_A + 32'(16 * ((k_m / 4) % 2));
      e.data = d;
      e.last = ((k_m % 8) == 7);
      exp_q.push_back(e);
      k_m++;
    end
    if (sof) synced_m = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.avl_write && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.avl_write) timeout_fail("avl_write_rise");
  endtask

  // Beat monitor: scoreboard compare, frame_done pulse, idle gap after each burst.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      fd_pend = 1'b0;
      gap_due = 1'b0;
      bib     = 0;
    end else begin
      if (fd_pend || frame_done) check("frame_done", 32'(frame_done), 32'(fd_pend));
      fd_pend = 1'b0;
      if (gap_due) begin
        check("idle_gap", 32'(bus.avl_write), 32'd0);
        gap_due = 1'b0;
      end
      if (bus.avl_write && !bus.avl_waitrequest) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: addr 0x%08h data 0x%08h, expected no beat", bus.avl_address, bus.avl_writedata);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", bus.avl_address, e.addr);
          check("beat_data", bus.avl_writedata, e.data);
          check("beat_burstcount", 32'(bus.avl_burstcount), 32'd4);
          fd_pend = e.last;
        end
        if (bib == 3) begin
          bib     = 0;
          gap_due = 1'b1;
        end else begin
          bib++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_acc;
    int base_beats;
    int n;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_sof   = 1'b0;
    bus.avl_waitrequest = 1'b0;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_write", 32'(bus.avl_write), 32'd0);
    check("rst_addr", bus.avl_address, BASE_A);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("byteenable", 32'(bus.avl_byteenable), 32'hF);
    check("avl_read", 32'(bus.avl_read), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_reset", 32'(bus.s_ready), 32'd1);

    // Sync: three dropped pixels, then one full frame starting with sof
    for (int i = 0; i < 3; i++) begin
      check("s_ready_unsynced", 32'(bus.s_ready), 32'd1);
      send(1'b0);
    end
    for (int i = 0; i < 8; i++) send(i == 0);
    wait_drain(200);
    check("addr_after_frame", bus.avl_address, BASE_A);
    check("frame_err_clean", 32'(frame_err), 32'd0);

    // Waitrequest stall on the third beat
    for (int i = 0; i < 4; i++) send(1'b0);
    wait_write(100);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.avl_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_write", 32'(bus.avl_write), 32'd1);
      if (exp_q.size() == 0) begin
        timeout_fail("stall_expect_empty");
      end else begin
        check("stall_addr", bus.avl_address, exp_q[0].addr);
        check("stall_data", bus.avl_writedata, exp_q[0].data);
      end
    end
    @(posedge clk);
    #1 bus.avl_waitrequest = 1'b0;
    wait_drain(200);

    // Backpressure: slave stalled, FIFO fills to DEPTH
    bus.avl_waitrequest = 1'b1;
    base_acc = accepts;
    tx_done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(1'b0);
        tx_done = 1'b1;
      end
    join_none
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("bp_s_ready", 32'(bus.s_ready), 32'd0);
    check("bp_accepts", 32'(accepts - base_acc), 32'd8);
    check("bp_count", 32'(dut.u_fifo.count), 32'd8);
    @(posedge clk);
    #1 bus.avl_waitrequest = 1'b0;
    n = 0;
    while (!tx_done && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (!tx_done) timeout_fail("bp_sender");
    #1;
    wait_drain(300);

    // Continuous stream: two frames back to back
    for (int i = 0; i < 16; i++) send((i % 8) == 0);
    wait_drain(300);

    // Stray sof on the third pixel of a frame
    check("frame_err_before", 32'(frame_err), 32'd0);
    for (int i = 0; i < 8; i++) send(i == 0 || i == 2);
    check("frame_err_set", 32'(frame_err), 32'd1);
    wait_drain(300);
    check("frame_err_sticky", 32'(frame_err), 32'd1);

    // Reset in the middle of the second burst of a frame
    base_beats = beats_seen;
    for (int i = 0; i < 8; i++) send(i == 0);
    n = 0;
    @(negedge clk);
    while (beats_seen < base_beats + 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (beats_seen < base_beats + 6) timeout_fail("mid_burst_wait");
    @(posedge clk);
    #1;
    check("pre_reset_addr", bus.avl_address, BASE_A + 32'h10);
    reset_n = 1'b0;
    exp_q.delete();
    k_m      = 0;
    synced_m = 1'b0;
    #1;
    check("async_rst_write", 32'(bus.avl_write), 32'd0);
    check("async_rst_addr", bus.avl_address, BASE_A);
    check("async_rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_reset2", 32'(bus.s_ready), 32'd1);
    for (int i = 0; i < 4; i++) send(1'b0);
    repeat (15) @(negedge clk);
    check("unsynced_no_write", 32'(bus.avl_write), 32'd0);
    check("unsynced_fifo_empty", 32'(dut.u_fifo.count), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(i == 0);
    wait_drain(200);
    check("final_addr", bus.avl_address, BASE_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
